// File: rtl/zoom_pkg.sv
// Shared definitions for the pixel-replication zoom engine.
package zoom_pkg;

    // Controller states
    typedef enum logic [2:0] {
        OCIOSO   = 3'd0,
        LER      = 3'd1,
        ESPERA   = 3'd2,
        ESCREVER = 3'd3,
        FIM      = 3'd4
    } estado_t;

    // Bits needed to hold the values 0..n-1 (never less than one bit)
    function automatic int largura(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/zoom_contador_coord.sv
// Nested rep/sx/dy counters walking the destination frame in raster order.
// rep counts the copies of one source pixel, sx the source column, dy the
// destination row. Everything advances only on an accepted destination write.
module zoom_contador_coord
    import zoom_pkg::*;
#(
    parameter int SRC_W         = 160,
    parameter int SRC_H         = 120,
    parameter int MAX_ZOOM_LOG2 = 2,
    parameter int KW            = 2,
    parameter int RW            = 2,
    parameter int XW            = 8,
    parameter int YW            = 9
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          limpar,
    input  logic          habilita,
    input  logic [KW-1:0] k,
    output logic [RW-1:0] rep,
    output logic [XW-1:0] sx,
    output logic [YW-1:0] dy,
    output logic          rep_ult,
    output logic          sx_ult,
    output logic          dy_ult
);

    logic [31:0] f_menos1;
    logic [31:0] dy_max;

    // Wrap points depend on the zoom factor latched for this frame
    always_comb begin
        f_menos1 = (32'd1 << k) - 32'd1;
        dy_max   = (32'(SRC_H) << k) - 32'd1;
        rep_ult  = (32'(rep) == f_menos1);
        sx_ult   = (32'(sx) == 32'(SRC_W - 1));
        dy_ult   = (32'(dy) == dy_max);
    end

    // rep is innermost, then sx, then dy; the last dy is held until the next clear
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rep <= '0;
            sx  <= '0;
            dy  <= '0;
        end else if (limpar) begin
            rep <= '0;
            sx  <= '0;
            dy  <= '0;
        end else if (habilita) begin
            if (rep_ult) begin
                rep <= '0;
                if (sx_ult) begin
                    sx <= '0;
                    if (!dy_ult) dy <= dy + YW'(1);
                end else begin
                    sx <= sx + XW'(1);
                end
            end else begin
                rep <= rep + RW'(1);
            end
        end
    end

endmodule

// File: rtl/zoom_replicacao.sv
// Nearest-neighbour zoom: reads a SRC_W x SRC_H image, writes it scaled by
// 2^k into a destination RAM with a fixed row stride. Each destination row
// re-reads its source row, so only one pixel register is needed.
// Handshake: a destination write completes on a cycle where dst_wren and
// dst_pronto are both high; while dst_pronto is low, address/data/wren hold.
module zoom_replicacao
    import zoom_pkg::*;
#(
    parameter int PIXEL_W       = 8,
    parameter int SRC_W         = 160,
    parameter int SRC_H         = 120,
    parameter int MAX_ZOOM_LOG2 = 2,
    localparam int DST_STRIDE   = SRC_W << MAX_ZOOM_LOG2,
    localparam int SRC_AW       = $clog2(SRC_W * SRC_H),
    localparam int DST_AW       = $clog2(DST_STRIDE * (SRC_H << MAX_ZOOM_LOG2))
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               iniciar,
    input  logic [1:0]         fator_log2,
    output logic [SRC_AW-1:0]  src_addr,
    output logic               src_rden,
    input  logic [PIXEL_W-1:0] src_q,
    output logic [DST_AW-1:0]  dst_addr,
    output logic [PIXEL_W-1:0] dst_data,
    output logic               dst_wren,
    input  logic               dst_pronto,
    output logic               ocupado,
    output logic               concluido,
    output estado_t            estado_dbg
);

    localparam int KW = largura(MAX_ZOOM_LOG2 + 1);
    localparam int RW = (MAX_ZOOM_LOG2 < 1) ? 1 : MAX_ZOOM_LOG2;
    localparam int XW = largura(SRC_W);
    localparam int YW = largura(SRC_H << MAX_ZOOM_LOG2);

    estado_t           estado, estado_prox;
    logic [KW-1:0]     k;
    logic [KW-1:0]     k_pedido;
    logic [PIXEL_W-1:0] pixel;
    logic [RW-1:0]     rep;
    logic [XW-1:0]     sx;
    logic [YW-1:0]     dy;
    logic              rep_ult, sx_ult, dy_ult;
    logic              aceita, habilita;

    assign aceita   = (estado == OCIOSO) && iniciar;
    assign habilita = (estado == ESCREVER) && dst_pronto;
    assign k_pedido = (32'(fator_log2) > 32'(MAX_ZOOM_LOG2)) ? KW'(MAX_ZOOM_LOG2)
                                                             : KW'(fator_log2);
    assign estado_dbg = estado;

    zoom_contador_coord #(
        .SRC_W(SRC_W), .SRC_H(SRC_H), .MAX_ZOOM_LOG2(MAX_ZOOM_LOG2),
        .KW(KW), .RW(RW), .XW(XW), .YW(YW)
    ) u_coord (
        .clock(clock), .reset_n(reset_n), .limpar(aceita), .habilita(habilita),
        .k(k), .rep(rep), .sx(sx), .dy(dy),
        .rep_ult(rep_ult), .sx_ult(sx_ult), .dy_ult(dy_ult)
    );

    // State register, latched zoom factor, pixel register and busy flag
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado  <= OCIOSO;
            k       <= '0;
            pixel   <= '0;
            ocupado <= 1'b0;
        end else begin
            estado  <= estado_prox;
            ocupado <= (estado_prox == LER) || (estado_prox == ESPERA) ||
                       (estado_prox == ESCREVER);
            if (aceita) k <= k_pedido;
            if (estado == ESPERA) pixel <= src_q;
        end
    end

    // Next state and per-state outputs; addresses are forced to 0 outside their state
    always_comb begin
        estado_prox = estado;
        src_rden    = 1'b0;
        src_addr    = '0;
        dst_wren    = 1'b0;
        dst_addr    = '0;
        dst_data    = '0;
        concluido   = 1'b0;
        case (estado)
            OCIOSO: begin
                if (iniciar) estado_prox = LER;
            end
            LER: begin
                src_rden    = 1'b1;
                src_addr    = SRC_AW'(dy >> k) * SRC_AW'(SRC_W) + SRC_AW'(sx);
                estado_prox = ESPERA;
            end
            ESPERA: begin
                estado_prox = ESCREVER;
            end
            ESCREVER: begin
                dst_wren = 1'b1;
                dst_data = pixel;
                dst_addr = DST_AW'(dy) * DST_AW'(DST_STRIDE) + (DST_AW'(sx) << k) + DST_AW'(rep);
                if (dst_pronto && rep_ult)
                    estado_prox = (sx_ult && dy_ult) ? FIM : LER;
            end
            FIM: begin
                concluido   = 1'b1;
                estado_prox = OCIOSO;
            end
            default: estado_prox = OCIOSO;
        endcase
    end

endmodule

// File: tb/tb_zoom_replicacao.sv
// Directed bench for zoom_replicacao with a 4x3 source image, max zoom x4.
module tb_zoom_replicacao;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       iniciar = 1'b0;
    logic [1:0] fator_log2 = 2'd0;
    logic [3:0] src_addr;
    logic       src_rden;
    logic [7:0] src_q = '0;
    logic [7:0] dst_addr;
    logic [7:0] dst_data;
    logic       dst_wren;
    logic       dst_pronto = 1'b1;
    logic       ocupado;
    logic       concluido;
    logic [2:0] estado_dbg;

    int n_tests = 0;
    int n_fail  = 0;

    // Write log and activity counters filled by the monitor
    logic [15:0] got_q[$];
    int busy_cnt = 0, conc_cnt = 0, stall_cnt = 0, stall_err = 0;
    int b_got = 0, b_busy = 0, b_conc = 0, b_stall = 0;
    logic        prev_stall = 1'b0;
    logic [16:0] prev_out = '0;

    int x1_addr[12] = '{0, 1, 2, 3, 16, 17, 18, 19, 32, 33, 34, 35};

    // Clock
    always #5 clock = ~clock;

    zoom_replicacao #(.PIXEL_W(8), .SRC_W(4), .SRC_H(3), .MAX_ZOOM_LOG2(2)) dut (
        .clock(clock), .reset_n(reset_n), .iniciar(iniciar), .fator_log2(fator_log2),
        .src_addr(src_addr), .src_rden(src_rden), .src_q(src_q),
        .dst_addr(dst_addr), .dst_data(dst_data), .dst_wren(dst_wren),
        .dst_pronto(dst_pronto), .ocupado(ocupado), .concluido(concluido),
        .estado_dbg(estado_dbg)
    );

    // Source RAM model: registered read, pixel value equals its address
    always @(posedge clock) begin
        if (src_rden) src_q <= {4'd0, src_addr};
    end

    // Monitor on the falling edge
    always @(negedge clock) begin
        if (dst_wren && dst_pronto) got_q.push_back({dst_addr, dst_data});
        if (ocupado) busy_cnt++;
        if (concluido) conc_cnt++;
        if (prev_stall && (prev_out !== {dst_wren, dst_addr, dst_data})) stall_err++;
        if (dst_wren && !dst_pronto) stall_cnt++;
        prev_stall = dst_wren && !dst_pronto;
        prev_out   = {dst_wren, dst_addr, dst_data};
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic snap();
        b_got   = got_q.size();
        b_busy  = busy_cnt;
        b_conc  = conc_cnt;
        b_stall = stall_cnt;
    endtask

    task automatic start(input logic [1:0] f);
        snap();
        iniciar    = 1'b1;
        fator_log2 = f;
        step();
        iniciar    = 1'b0;
    endtask

    // Returns in the cycle where concluido is high
    task automatic wait_fim(input string tag);
        int n;
        n = 0;
        while (!concluido && n < 2000) begin
            step();
            n++;
        end
        chk({tag, "_timeout"}, {31'd0, concluido}, 32'd1);
    endtask

    // Compares the writes of the last frame against the raster model
    task automatic check_frame(input int k, input string tag, input int exp_busy);
        int f, idx;
        logic [15:0] e;
        step();
        f = 1 << k;
        chk({tag, "_writes"}, 32'(got_q.size() - b_got), 32'(12 * f * f));
        idx = b_got;
        for (int y = 0; y < 3 * f; y++)
            for (int x = 0; x < 4; x++)
                for (int r = 0; r < f; r++) begin
                    e[15:8] = 8'(y * 16 + x * f + r);
                    e[7:0]  = 8'((y >> k) * 4 + x);
                    if (idx < got_q.size())
                        chk($sformatf("%s_w%0d", tag, idx - b_got), 32'(got_q[idx]), 32'(e));
                    idx++;
                end
        chk({tag, "_busy"}, 32'(busy_cnt - b_busy), 32'(exp_busy));
        chk({tag, "_concluido"}, 32'(conc_cnt - b_conc), 32'd1);
        chk({tag, "_idle"}, {31'd0, ocupado}, 32'd0);
    endtask

    initial begin
        // Reset state
        step();
        chk("rst_ocupado", {31'd0, ocupado}, 32'd0);
        chk("rst_wren", {31'd0, dst_wren}, 32'd0);
        chk("rst_rden", {31'd0, src_rden}, 32'd0);
        chk("rst_estado", 32'(estado_dbg), 32'd0);
        reset_n = 1'b1;
        step();
        step();

        // Zoom x1
        start(2'd0);
        chk("x1_ocupado_start", {31'd0, ocupado}, 32'd1);
        wait_fim("x1");
        check_frame(0, "x1", 36);
        for (int i = 0; i < 12; i++)
            if (b_got + i < got_q.size()) begin
                chk($sformatf("x1_hand_addr%0d", i), 32'(got_q[b_got + i][15:8]), 32'(x1_addr[i]));
                chk($sformatf("x1_hand_data%0d", i), 32'(got_q[b_got + i][7:0]), 32'(i));
            end
        step();

        // Zoom x2
        start(2'd1);
        wait_fim("x2");
        check_frame(1, "x2", 96);
        if (got_q.size() >= b_got + 24) begin
            chk("x2_r0_a3", 32'(got_q[b_got + 3]), 32'({8'd3, 8'd1}));
            chk("x2_r0_a6", 32'(got_q[b_got + 6]), 32'({8'd6, 8'd3}));
            chk("x2_r1_a16", 32'(got_q[b_got + 8]), 32'({8'd16, 8'd0}));
            chk("x2_r1_a23", 32'(got_q[b_got + 15]), 32'({8'd23, 8'd3}));
            chk("x2_r2_a34", 32'(got_q[b_got + 18]), 32'({8'd34, 8'd5}));
        end
        step();

        // Zoom clamp: factor code 3 behaves as x4
        start(2'd3);
        wait_fim("x4");
        check_frame(2, "clamp", 288);
        chk("clamp_last", 32'(got_q[got_q.size() - 1]), 32'({8'd191, 8'd11}));
        step();

        // Backpressure: five stalled cycles in the middle of a write burst
        start(2'd0);
        for (int n = 0; n < 200 && !(dst_wren && got_q.size() >= b_got + 3); n++) step();
        chk("bp_in_write", {31'd0, dst_wren}, 32'd1);
        dst_pronto = 1'b0;
        repeat (5) step();
        dst_pronto = 1'b1;
        wait_fim("bp");
        check_frame(0, "bp", 41);
        chk("bp_stall_cycles", 32'(stall_cnt - b_stall), 32'd5);
        chk("bp_stable", 32'(stall_err), 32'd0);
        step();

        // Reset mid-frame at x2
        start(2'd1);
        for (int n = 0; n < 200 && got_q.size() < b_got + 3; n++) step();
        chk("rm_in_frame", {31'd0, ocupado}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("rm_wren", {31'd0, dst_wren}, 32'd0);
        chk("rm_ocupado", {31'd0, ocupado}, 32'd0);
        chk("rm_addr", 32'(dst_addr), 32'd0);
        chk("rm_data", 32'(dst_data), 32'd0);
        chk("rm_rden", {31'd0, src_rden}, 32'd0);
        repeat (3) step();
        reset_n = 1'b1;
        snap();
        repeat (10) step();
        chk("rm_no_writes", 32'(got_q.size() - b_got), 32'd0);
        chk("rm_idle", {31'd0, ocupado}, 32'd0);
        start(2'd1);
        wait_fim("rm");
        check_frame(1, "rm_new", 96);
        step();

        // Start while busy, and start during the completion cycle
        start(2'd0);
        repeat (5) step();
        iniciar    = 1'b1;
        fator_log2 = 2'd2;
        step();
        iniciar = 1'b0;
        repeat (10) step();
        iniciar = 1'b1;
        step();
        iniciar = 1'b0;
        wait_fim("busy");
        iniciar = 1'b1;
        step();
        iniciar = 1'b0;
        check_frame(0, "busy", 36);
        repeat (5) step();
        chk("fim_start_ignored", {31'd0, ocupado}, 32'd0);
        chk("fim_no_writes", 32'(got_q.size() - b_got), 32'd12);
        chk("fim_one_concluido", 32'(conc_cnt - b_conc), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
